// File: rtl/if_pc_unit.sv
// Instruction-fetch PC unit: PC register, IF/ID pipeline register and RUN/HALTED(/STEP) debug FSM.
// Define IF_DEBUG_STEP_EN to compile in single-step support (step input and STEP state).
module if_pc_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_dir,
    input  logic        branch_taken,
    input  logic [31:0] branch_dir,
    input  logic        resume,
    input  logic        step,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_pc_plus_4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted
);

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

`ifdef IF_DEBUG_STEP_EN
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    logic [31:0] pc_plus_4;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Result of one fetch attempt, shared by RUN and STEP.
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc4;
    logic [31:0] fetch_instr;
    logic        fetch_valid;
    logic        fetch_halt;

`ifndef IF_DEBUG_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    assign pc_plus_4   = pc_q + 32'd4;
    assign redirect    = jump | branch_taken;
    assign redirect_pc = jump ? jump_dir : branch_dir;

    always_comb begin
        fetch_pc    = pc_plus_4;
        fetch_pc4   = 32'd0;
        fetch_instr = 32'd0;
        fetch_valid = 1'b0;
        fetch_halt  = 1'b0;
        if (redirect) begin
            fetch_pc = redirect_pc;
        end else if (imem_data == HALT_WORD) begin
            fetch_halt = 1'b1;
        end else begin
            fetch_pc4   = pc_plus_4;
            fetch_instr = imem_data;
            fetch_valid = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;

        case (state_q)
            RUN: begin
                if (!stall) begin
                    pc_d    = fetch_pc;
                    pc4_d   = fetch_pc4;
                    instr_d = fetch_instr;
                    valid_d = fetch_valid;
                    if (fetch_halt) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                if (!stall) begin
                    pc4_d   = 32'd0;
                    instr_d = 32'd0;
                    valid_d = 1'b0;
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end
                end
                // Debug pulses are honoured even under stall so they are never lost.
                if (resume) begin
                    state_d = RUN;
`ifdef IF_DEBUG_STEP_EN
                end else if (step) begin
                    state_d = STEP;
`endif
                end
            end
`ifdef IF_DEBUG_STEP_EN
            STEP: begin
                if (!stall) begin
                    pc_d    = fetch_pc;
                    pc4_d   = fetch_pc4;
                    instr_d = fetch_instr;
                    valid_d = fetch_valid;
                    state_d = HALTED;
                end
            end
`endif
            default: begin
                state_d = RUN;
            end
        endcase

        halted_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= 32'd0;
            pc4_q    <= 32'd0;
            instr_q  <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr       = pc_q;
    assign if_id_pc_plus_4 = pc4_q;
    assign if_id_instr     = instr_q;
    assign if_id_valid     = valid_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_if_pc_unit.sv
// Self-checking bench for if_pc_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_pc_unit;

`ifdef IF_DEBUG_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_dir = 32'd0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_dir = 32'd0;
    logic        resume = 1'b0;
    logic        step = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'd0;
    logic [31:0] if_id_pc_plus_4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;

    if_pc_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .jump            (jump),
        .jump_dir        (jump_dir),
        .branch_taken    (branch_taken),
        .branch_dir      (branch_dir),
        .resume          (resume),
        .step            (step),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .if_id_pc_plus_4 (if_id_pc_plus_4),
        .if_id_instr     (if_id_instr),
        .if_id_valid     (if_id_valid),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: mode 0 = running, 1 = halted, 2 = single-stepping.
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid;
    int          m_mode;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_mode = 0;
    endtask

    task automatic model_bubble();
        m_pc4 = 0; m_instr = 0; m_valid = 0;
    endtask

    task automatic model_edge();
        bit was_step;
        if (m_mode == 1) begin
            if (!stall) begin
                model_bubble();
                if (jump) m_pc = jump_dir;
                else if (branch_taken) m_pc = branch_dir;
            end
            if (resume) m_mode = 0;
            else if (step && STEP_EN) m_mode = 2;
            return;
        end
        if (stall) return;
        was_step = (m_mode == 2);
        if (jump) begin
            m_pc = jump_dir; model_bubble();
        end else if (branch_taken) begin
            m_pc = branch_dir; model_bubble();
        end else if (imem_data == 32'hFFFF_FFFF) begin
            m_pc = m_pc + 4; model_bubble(); m_mode = 1;
        end else begin
            m_pc4 = m_pc + 4; m_instr = imem_data; m_valid = 1; m_pc = m_pc + 4;
        end
        if (was_step) m_mode = 1;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".addr"}, imem_addr, m_pc);
        check_eq({tag, ".pc4"}, if_id_pc_plus_4, m_pc4);
        check_eq({tag, ".instr"}, if_id_instr, m_instr);
        check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check_eq({tag, ".halted"}, {31'd0, halted}, {31'd0, m_mode != 0});
    endtask

    // Called at a negedge with inputs set; advances one clock and checks at the next negedge.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        stall = 0; jump = 0; branch_taken = 0; resume = 0; step = 0;
        jump_dir = 0; branch_dir = 0;
        imem_data = 32'h0000_1000 | ($urandom & 32'h00FF_FFF0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_eq({tag, ".rst_addr"}, imem_addr, 32'd0);
        check_eq({tag, ".rst_pc4"}, if_id_pc_plus_4, 32'd0);
        check_eq({tag, ".rst_instr"}, if_id_instr, 32'd0);
        check_eq({tag, ".rst_valid"}, {31'd0, if_id_valid}, 32'd0);
        check_eq({tag, ".rst_halted"}, {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        idle_inputs();
    endtask

    task automatic run_to_0x20();
        do_reset("pre");
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            tick("walk");
        end
        check_eq("walk.addr20", imem_addr, 32'h20);
    endtask

    logic [31:0] s_pc4, s_instr;

    initial begin
        model_reset();
        do_reset("init");

        // First fetch after reset.
        imem_data = 32'h2008_0001;
        tick("r34");
        check_eq("r34.pc4", if_id_pc_plus_4, 32'h4);
        check_eq("r34.instr", if_id_instr, 32'h2008_0001);
        check_eq("r34.valid", {31'd0, if_id_valid}, 32'd1);
        check_eq("r34.addr", imem_addr, 32'h4);

        // Walk to 0x10, then stalled jump, then real jump.
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            tick("walk10");
        end
        check_eq("r35.at10", imem_addr, 32'h10);
        s_pc4 = if_id_pc_plus_4; s_instr = if_id_instr;
        idle_inputs();
        jump = 1; jump_dir = 32'h0040_0000; stall = 1;
        tick("r35s");
        check_eq("r35.stall_addr", imem_addr, 32'h10);
        check_eq("r35.stall_pc4", if_id_pc_plus_4, s_pc4);
        check_eq("r35.stall_instr", if_id_instr, s_instr);
        check_eq("r35.stall_valid", {31'd0, if_id_valid}, 32'd1);
        stall = 0;
        tick("r35j");
        check_eq("r35.jaddr", imem_addr, 32'h0040_0000);
        check_eq("r35.jvalid", {31'd0, if_id_valid}, 32'd0);

        // Jump beats branch.
        idle_inputs();
        jump = 1; jump_dir = 32'h100; branch_taken = 1; branch_dir = 32'h200;
        tick("r36");
        check_eq("r36.addr", imem_addr, 32'h100);
        idle_inputs();
        branch_taken = 1; branch_dir = 32'h200;
        tick("br");
        check_eq("br.addr", imem_addr, 32'h200);

        // PC+4 wraps at the top of the address space.
        idle_inputs();
        jump = 1; jump_dir = 32'hFFFF_FFFC;
        tick("wrapj");
        idle_inputs();
        imem_data = 32'h1234_5678;
        tick("wrap");
        check_eq("wrap.addr", imem_addr, 32'h0);
        check_eq("wrap.pc4", if_id_pc_plus_4, 32'h0);
        check_eq("wrap.valid", {31'd0, if_id_valid}, 32'd1);

        // HALT at 0x20, hold, resume.
        run_to_0x20();
        imem_data = 32'hFFFF_FFFF;
        tick("r37h");
        check_eq("r37.halted", {31'd0, halted}, 32'd1);
        check_eq("r37.addr", imem_addr, 32'h24);
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            tick("r37hold");
            check_eq("r37.hold_addr", imem_addr, 32'h24);
            check_eq("r37.hold_valid", {31'd0, if_id_valid}, 32'd0);
        end
        idle_inputs();
        resume = 1;
        tick("r37r");
        check_eq("r37.run", {31'd0, halted}, 32'd0);
        idle_inputs();
        imem_data = 32'h0000_ABCD;
        tick("r37f");
        check_eq("r37.fvalid", {31'd0, if_id_valid}, 32'd1);
        check_eq("r37.fpc4", if_id_pc_plus_4, 32'h28);

        // Single step from 0x24.
        run_to_0x20();
        imem_data = 32'hFFFF_FFFF;
        tick("r38h");
        idle_inputs();
        step = 1;
        tick("r38s");
        idle_inputs();
        tick("r38f");
        if (STEP_EN) begin
            check_eq("r38.valid", {31'd0, if_id_valid}, 32'd1);
            check_eq("r38.pc4", if_id_pc_plus_4, 32'h28);
            check_eq("r38.addr", imem_addr, 32'h28);
        end else begin
            check_eq("r38.valid", {31'd0, if_id_valid}, 32'd0);
            check_eq("r38.addr", imem_addr, 32'h24);
        end
        check_eq("r38.halted", {31'd0, halted}, 32'd1);
        idle_inputs();
        tick("r38after");
        check_eq("r38.after_valid", {31'd0, if_id_valid}, 32'd0);

        // Randomized traffic with occasional mid-run resets.
        do_reset("rnd");
        for (int i = 0; i < 2000; i++) begin
            if (i % 400 == 399) begin
                stall = $urandom_range(0, 1);
                do_reset("rndrst");
            end
            stall        = ($urandom_range(0, 3) == 0);
            jump         = ($urandom_range(0, 9) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            jump_dir     = $urandom & 32'hFFFF_FFFC;
            branch_dir   = $urandom & 32'hFFFF_FFFC;
            resume       = ($urandom_range(0, 7) == 0);
            step         = ($urandom_range(0, 5) == 0);
            if (resume || step) stall = 0;
            imem_data    = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFF : $urandom;
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
